microwave_countdown_timer: RTL and testbench

Countdown timer core of the microwave. Collects keypad digits into a three-digit M:SS BCD time, then counts down once per 1 Hz tick while cooking. Supports pause, resume and clear. Feeds the minutes, tens_sec and units_sec digits directly into the downstream 7-segment decoder, and drives the magnetron-enable and done indications.

---
 rtl/microwave_countdown_timer_if.sv | 25 ++
 rtl/microwave_countdown_timer.sv | 147 ++++++++++++++
 tb/tb_microwave_countdown_timer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/microwave_countdown_timer_if.sv
// Control and display signals of the microwave countdown timer.
// master drives keypad/buttons/door/tick, slave drives the digits and status.
interface microwave_countdown_timer_if;
  logic       tick_1hz;
  logic       keypad_valid;
  logic [3:0] keypad_digit;
  logic       start;
  logic       stop_clear;
  logic       door_open;
  logic [3:0] minutes;
  logic [3:0] tens_sec;
  logic [3:0] units_sec;
  logic       heating;
  logic       done;

  modport master (
    output tick_1hz, keypad_valid, keypad_digit, start, stop_clear, door_open,
    input  minutes, tens_sec, units_sec, heating, done
  );

  modport slave (
    input  tick_1hz, keypad_valid, keypad_digit, start, stop_clear, door_open,
    output minutes, tens_sec, units_sec, heating, done
  );
endinterface

// File: rtl/microwave_countdown_timer.sv
// M:SS BCD keypad-entry countdown timer with pause/resume/clear.
// Optional quick-start (+30 s) feature enabled by defining QUICK_START_EN.
module microwave_countdown_timer #(
  parameter int TENS_WRAP       = 5,
  parameter int QUICK_SECS_TENS = 3
) (
  input  logic clock,
  input  logic reset_n,
  microwave_countdown_timer_if.slave bus
);

`ifdef QUICK_START_EN
  localparam bit QUICK_EN = 1'b1;
`else
  localparam bit QUICK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t     state_reg;
  logic [3:0] minutes_reg, tens_reg, units_reg;
  logic       heating_reg, done_reg;

  logic       time_zero, last_second, digit_ok, add_carry;
  logic [3:0] dec_minutes, dec_tens, dec_units;
  logic [3:0] add_minutes, add_tens, add_units;

  always_comb begin
    time_zero   = (minutes_reg == 4'd0) && (tens_reg == 4'd0) && (units_reg == 4'd0);
    last_second = (minutes_reg == 4'd0) && (tens_reg == 4'd0) && (units_reg == 4'd1);
    digit_ok    = (bus.keypad_digit <= 4'd9);

    dec_minutes = minutes_reg;
    dec_tens    = tens_reg;
    dec_units   = units_reg;
    if (units_reg != 4'd0) begin
      dec_units = units_reg - 4'd1;
    end else if (tens_reg != 4'd0) begin
      dec_tens  = tens_reg - 4'd1;
      dec_units = 4'd9;
    end else if (minutes_reg != 4'd0) begin
      dec_minutes = minutes_reg - 4'd1;
      dec_tens    = 4'(TENS_WRAP);
      dec_units   = 4'd9;
    end

    // +30 s: tens+3 reaching 6 or more borrows six tens into one minute
    add_carry   = (tens_reg >= 4'd3);
    add_minutes = minutes_reg + {3'd0, add_carry};
    add_tens    = add_carry ? (tens_reg - 4'd3) : (tens_reg + 4'd3);
    add_units   = units_reg;
    if (add_carry && (minutes_reg >= 4'd9)) begin
      add_minutes = 4'd9;
      add_tens    = 4'd5;
      add_units   = 4'd9;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      minutes_reg <= 4'd0;
      tens_reg    <= 4'd0;
      units_reg   <= 4'd0;
      heating_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.stop_clear) begin
            minutes_reg <= 4'd0;
            tens_reg    <= 4'd0;
            units_reg   <= 4'd0;
          end else if (bus.start && !bus.door_open && !time_zero) begin
            state_reg   <= RUNNING;
            heating_reg <= 1'b1;
          end else if (QUICK_EN && bus.start && !bus.door_open && time_zero) begin
            tens_reg    <= 4'(QUICK_SECS_TENS);
            state_reg   <= RUNNING;
            heating_reg <= 1'b1;
          end else if (bus.keypad_valid && digit_ok) begin
            minutes_reg <= tens_reg;
            tens_reg    <= units_reg;
            units_reg   <= bus.keypad_digit;
          end
        end

        RUNNING: begin
          if (bus.stop_clear || bus.door_open) begin
            state_reg   <= PAUSED;
            heating_reg <= 1'b0;
          end else if (QUICK_EN && bus.start) begin
            minutes_reg <= add_minutes;
            tens_reg    <= add_tens;
            units_reg   <= add_units;
          end else if (bus.tick_1hz) begin
            minutes_reg <= dec_minutes;
            tens_reg    <= dec_tens;
            units_reg   <= dec_units;
            if (last_second) begin
              state_reg   <= DONE;
              heating_reg <= 1'b0;
              done_reg    <= 1'b1;
            end
          end
        end

        PAUSED: begin
          if (bus.stop_clear) begin
            state_reg   <= IDLE;
            minutes_reg <= 4'd0;
            tens_reg    <= 4'd0;
            units_reg   <= 4'd0;
          end else if (bus.start && !bus.door_open) begin
            state_reg   <= RUNNING;
            heating_reg <= 1'b1;
          end
        end

        DONE: begin
          // Time is already 0:00 here, so a keypad digit lands as 0:0d
          if (bus.stop_clear) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
          end else if (bus.keypad_valid && digit_ok) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
            units_reg <= bus.keypad_digit;
          end
        end

        default: begin
          state_reg   <= IDLE;
          heating_reg <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.minutes   = minutes_reg;
  assign bus.tens_sec  = tens_reg;
  assign bus.units_sec = units_reg;
  assign bus.heating   = heating_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_microwave_countdown_timer.sv
// Scoreboard bench for microwave_countdown_timer: directed scenarios then random
// stimulus, each cycle's expected display predicted by a digit-level model.
module tb_microwave_countdown_timer;

  localparam int TW = 5;
  localparam int QT = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  microwave_countdown_timer_if bus ();

  microwave_countdown_timer #(
    .TENS_WRAP       (TW),
    .QUICK_SECS_TENS (QT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

`ifdef QUICK_START_EN
  localparam bit QUICK = 1'b1;
`else
  localparam bit QUICK = 1'b0;
`endif

  // Reference model: three decimal digits and a named mode
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t mode = M_IDLE;
  int mm = 0, tt = 0, uu = 0;

  logic [13:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bit door = 1'b0;

  function automatic int secs_total();
    return mm * 100 + tt * 10 + uu;
  endfunction

  task automatic model_step(input bit rst, input bit tick, input bit kv, input int d,
                            input bit st, input bit sc, input bit dr);
    if (rst) begin
      mode = M_IDLE; mm = 0; tt = 0; uu = 0;
      return;
    end
    case (mode)
      M_IDLE: begin
        if (sc) begin
          mm = 0; tt = 0; uu = 0;
        end else if (st && !dr && secs_total() != 0) begin
          mode = M_RUN;
        end else if (QUICK && st && !dr) begin
          mm = 0; tt = QT; uu = 0; mode = M_RUN;
        end else if (kv && d <= 9) begin
          mm = tt; tt = uu; uu = d;
        end
      end
      M_RUN: begin
        if (sc || dr) begin
          mode = M_PAUSE;
        end else if (QUICK && st) begin
          tt = tt + 3;
          if (tt >= 6) begin tt = tt - 6; mm = mm + 1; end
          if (mm > 9) begin mm = 9; tt = 5; uu = 9; end
        end else if (tick) begin
          if (uu > 0) uu = uu - 1;
          else if (tt > 0) begin tt = tt - 1; uu = 9; end
          else begin mm = mm - 1; tt = TW; uu = 9; end
          if (secs_total() == 0) mode = M_DONE;
        end
      end
      M_PAUSE: begin
        if (sc) begin
          mode = M_IDLE; mm = 0; tt = 0; uu = 0;
        end else if (st && !dr) begin
          mode = M_RUN;
        end
      end
      M_DONE: begin
        if (sc) mode = M_IDLE;
        else if (kv && d <= 9) begin mode = M_IDLE; uu = d; end
      end
      default: mode = M_IDLE;
    endcase
  endtask

  // One clock of stimulus; the expected post-edge display goes to the scoreboard
  task automatic step(input bit rst, input bit tick, input bit kv, input int d,
                      input bit st, input bit sc, input bit dr);
    reset_n          = !rst;
    bus.tick_1hz     = tick;
    bus.keypad_valid = kv;
    bus.keypad_digit = 4'(d);
    bus.start        = st;
    bus.stop_clear   = sc;
    bus.door_open    = dr;
    @(posedge clock);
    model_step(rst, tick, kv, d, st, sc, dr);
    exp_q.push_back({4'(mm), 4'(tt), 4'(uu), mode == M_RUN, mode == M_DONE});
    @(negedge clock);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, door);
  endtask

  task automatic key(input int d);
    step(0, 0, 1, d, 0, 0, door);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0, 0, 0, door);
      step(0, 0, 0, 0, 0, 0, door);
    end
  endtask

  always @(negedge clock) begin
    logic [13:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {bus.minutes, bus.tens_sec, bus.units_sec, bus.heating, bus.done};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL vec%0d display got %0d:%0d%0d heat=%b done=%b want %0d:%0d%0d heat=%b done=%b",
                 vectors, g[13:10], g[9:6], g[5:2], g[1], g[0], e[13:10], e[9:6], e[5:2], e[1], e[0]);
      end else begin
        $display("vec%0d %0d:%0d%0d heat=%b done=%b", vectors, g[13:10], g[9:6], g[5:2], g[1], g[0]);
      end
    end
  end

  initial begin
    bus.tick_1hz = 0; bus.keypad_valid = 0; bus.keypad_digit = 0;
    bus.start = 0; bus.stop_clear = 0; bus.door_open = 0;
    @(negedge clock);

    // Reset, 1:30, count through the minute borrow
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    key(1); key(3); key(0);
    step(0, 0, 0, 0, 1, 0, 0);
    ticks(31);

    // 0:05 to DONE, extra tick, clear
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    key(5);
    step(0, 1, 0, 0, 1, 0, 0);
    ticks(6);
    step(0, 0, 0, 0, 0, 1, 0);

    // 2:00, door with tick, start with door high ignored, resume
    key(2); key(0); key(0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    ticks(1);
    step(0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // 1,2,3,4 -> 2:34; digit 12 ignored; clear; start at 0:00
    key(1); key(2); key(3); key(4); key(12);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    // Unnormalised 1:90 and DONE-to-keypad reload
    key(1); key(9); key(0);
    step(0, 0, 0, 0, 1, 0, 0);
    ticks(12);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    key(2);
    step(0, 0, 0, 0, 1, 0, 0);
    ticks(2);
    key(7);

    // Quick start behaviour (0:30 load, +30 s, saturation)
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    ticks(5);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    key(9); key(4); key(5);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Reset mid-run at 3:17
    key(3); key(1); key(7);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    idle_cycles(2);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      bit r, tk, kv, st, sc;
      int d;
      if ($urandom_range(99) < 2) door = !door;
      r  = ($urandom_range(999) < 3);
      tk = ($urandom_range(99) < 25);
      kv = ($urandom_range(99) < 12);
      st = ($urandom_range(99) < 6);
      sc = ($urandom_range(99) < 2);
      d  = $urandom_range(15);
      step(r, tk, kv, d, st, sc, door);
    end

    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
